// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and framing constants
package uart_pkg;
    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: circular byte buffer with combinational head read
// Ports: clk, reset (async active-low), push/push_data write side,
//        pop read side, head = oldest byte, full/empty flags, count = occupancy.
// A push while full is accepted only if a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        do_pop, do_push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 oversampling receiver feeding a byte FIFO
// Ports: clk, reset (async active-low), rx serial line (idles high),
//        uart_out_valid consumer request, uart_out_ready/uart_out_data delivery,
//        fifo_count occupancy, frame_error/overrun sticky flags, error_clear.
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          uart_out_valid,
    output logic [7:0]                    uart_out_data,
    output logic                          uart_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_error,
    output logic                          overrun,
    input  logic                          error_clear
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    uart_rx_state_t            state;
    logic [CW-1:0]             bit_cnt;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      rx_m, rx_s;
    logic                      stop_edge, push, bad_stop, full, empty, drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m <= UART_IDLE_LEVEL;
            rx_s <= UART_IDLE_LEVEL;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // The push is decoded from the stop-sample edge itself so the byte lands
    // in the FIFO on that edge and is visible one cycle later.
    assign stop_edge      = state == STOP && bit_cnt == BIT_LAST;
    assign push           = stop_edge && rx_s;
    assign bad_stop       = stop_edge && !rx_s;
    assign uart_out_ready = uart_out_valid && !empty;
    assign drop           = push && full && !uart_out_ready;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (uart_out_ready),
        .head      (uart_out_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= WAIT_IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // Set events take priority over a simultaneous clear.
            frame_error <= bad_stop || (frame_error && !error_clear);
            overrun     <= drop || (overrun && !error_clear);
            case (state)
                WAIT_IDLE: if (rx_s == UART_IDLE_LEVEL) state <= IDLE;
                IDLE: if (rx_s != UART_IDLE_LEVEL) begin
                    state   <= START;
                    bit_cnt <= '0;
                end
                START: if (bit_cnt == HALF_LAST) begin
                    state   <= rx_s ? IDLE : DATA;
                    bit_cnt <= '0;
                    bit_idx <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                DATA: if (bit_cnt == BIT_LAST) begin
                    bit_cnt        <= '0;
                    shreg[bit_idx] <= rx_s;
                    bit_idx        <= bit_idx + 1'b1;
                    if (bit_idx == IW'(UART_DATA_BITS - 1)) state <= STOP;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                STOP: if (bit_cnt == BIT_LAST) begin
                    state   <= rx_s ? IDLE : WAIT_IDLE;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb_uart_byte_receiver: directed self-checking bench for the UART byte receiver
module tb_uart_byte_receiver;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clk = 0, reset = 1, rx = 1, uart_out_valid = 0, error_clear = 0;
    logic [7:0] uart_out_data;
    logic       uart_out_ready, frame_error, overrun;
    logic [2:0] fifo_count;

    int tests = 0, fails = 0, cyc = 0, s = 0;
    logic [7:0] got[$];
    int         got_cyc[$];

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         n_out;
        logic [7:0] exp_data;
        bit         exp_fe;
    } vec_t;
    vec_t vecs[5];
    logic [7:0] exp4[4];

    uart_byte_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx             (rx),
        .uart_out_valid (uart_out_valid),
        .uart_out_data  (uart_out_data),
        .uart_out_ready (uart_out_ready),
        .fifo_count     (fifo_count),
        .frame_error    (frame_error),
        .overrun        (overrun),
        .error_clear    (error_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (uart_out_ready) begin
        got.push_back(uart_out_data);
        got_cyc.push_back(cyc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line(input logic v, input int n);
        rx = v;
        tick(n);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int stop_len);
        s = cyc;
        line(0, CPB);
        for (int i = 0; i < 8; i++) line(b[i], CPB);
        line(stop, stop_len);
        rx = 1;
    endtask

    task automatic pulse_clear();
        error_clear = 1;
        tick(1);
        error_clear = 0;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1, 1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1, 1, 8'hFF, 0};
        vecs[3] = '{8'h5A, 0, 0, 8'h00, 1};
        vecs[4] = '{8'hC3, 1, 1, 8'hC3, 0};
        exp4 = '{8'h10, 8'h32, 8'h54, 8'h76};

        #2 reset = 0;
        #1;
        chk("reset_ready", uart_out_ready, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_data", uart_out_data, 0);
        chk("reset_flags", {frame_error, overrun}, 0);
        @(posedge clk);
        #1 reset = 1;
        tick(4);

        // Single frames with consumer requesting.
        uart_out_valid = 1;
        for (int v = 0; v < 5; v++) begin
            got.delete();
            got_cyc.delete();
            send(vecs[v].data, vecs[v].stop, CPB);
            tick(12);
            chk($sformatf("vec%0d_pulses", v), got.size(), vecs[v].n_out);
            if (got.size() > 0) chk($sformatf("vec%0d_data", v), got[0], vecs[v].exp_data);
            if (v == 0 && got.size() > 0) chk("vec0_latency", (got_cyc[0] - s) <= 10 * CPB + 4, 1);
            chk($sformatf("vec%0d_fe", v), frame_error, vecs[v].exp_fe);
            chk($sformatf("vec%0d_ov", v), overrun, 0);
            pulse_clear();
            chk($sformatf("vec%0d_fe_clr", v), frame_error, 0);
        end

        // Back-to-back frames buffered, then burst drain.
        uart_out_valid = 0;
        got.delete();
        got_cyc.delete();
        for (int i = 0; i < 4; i++) send(exp4[i], 1, CPB);
        tick(4);
        chk("b2b_count", fifo_count, 4);
        uart_out_valid = 1;
        tick(6);
        uart_out_valid = 0;
        chk("b2b_pulses", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk($sformatf("b2b_data%0d", i), got[i], exp4[i]);
            if (i > 0) chk($sformatf("b2b_consec%0d", i), got_cyc[i] - got_cyc[i-1], 1);
        end
        chk("b2b_count_end", fifo_count, 0);

        // Overrun on a full FIFO.
        for (int i = 0; i < 4; i++) send(exp4[i], 1, CPB);
        tick(4);
        chk("full_count", fifo_count, 4);
        chk("full_ov0", overrun, 0);
        send(8'hFF, 1, CPB);
        tick(4);
        chk("ovr_flag", overrun, 1);
        chk("ovr_count", fifo_count, 4);
        chk("ovr_head", uart_out_data, 8'h10);
        pulse_clear();
        chk("ovr_clear", overrun, 0);
        got.delete();
        uart_out_valid = 1;
        tick(6);
        chk("ovr_drain_n", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("ovr_drain%0d", i), got[i], exp4[i]);

        // Stop bit low followed by a held-low break.
        got.delete();
        send(8'h55, 0, CPB + 40);
        chk("brk_fe", frame_error, 1);
        chk("brk_nopush", got.size(), 0);
        tick(4);
        pulse_clear();
        send(8'h3C, 1, CPB);
        tick(12);
        chk("brk_next_n", got.size(), 1);
        if (got.size() > 0) chk("brk_next_data", got[0], 8'h3C);
        chk("brk_next_fe", frame_error, 0);

        // Short glitch on an idle line.
        got.delete();
        line(0, 3);
        line(1, 20);
        chk("glitch_n", got.size(), 0);
        chk("glitch_flags", {frame_error, overrun}, 0);
        send(8'h99, 1, CPB);
        tick(12);
        chk("glitch_next_n", got.size(), 1);
        if (got.size() > 0) chk("glitch_next_data", got[0], 8'h99);

        // Asynchronous reset in the middle of a frame.
        uart_out_valid = 0;
        send(8'h77, 1, CPB);
        tick(4);
        send(8'h5A, 0, CPB);
        tick(12);
        chk("pre_rst_count", fifo_count, 1);
        chk("pre_rst_fe", frame_error, 1);
        line(0, CPB);
        line(1, CPB);
        line(0, CPB);
        line(0, CPB / 2);
        uart_out_valid = 1;
        reset = 0;
        #2;
        chk("rst_ready", uart_out_ready, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", uart_out_data, 0);
        chk("rst_flags", {frame_error, overrun}, 0);
        rx = 1;
        tick(3);
        reset = 1;
        tick(3);
        got.delete();
        send(8'h42, 1, CPB);
        tick(12);
        chk("rst_next_n", got.size(), 1);
        if (got.size() > 0) chk("rst_next_data", got[0], 8'h42);
        chk("rst_next_count", fifo_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
